// File: rtl/can_rx_fifo.sv
// Receive message FIFO behind the CAN acceptance filter. Each 128-bit entry is
// read out as four 32-bit words, and a word-3 read pops the entry.
module can_rx_fifo #(
  parameter int DEPTH     = 64,
  parameter int WATERMARK = 48,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic          i_sys_clk,
  input  logic          i_reset,
  input  logic          i_rx_w_en,
  input  logic [127:0]  i_rx_fifo_w_data,
  output logic          o_rx_full,
  input  logic          i_rd_en,
  input  logic [1:0]    i_rd_word,
  output logic [31:0]   o_rd_data,
  output logic          o_rd_valid,
  output logic          o_empty,
  output logic          o_almost_full,
  output logic [AW:0]   o_fill_level,
  output logic          o_overflow,
  input  logic          i_overflow_clr,
  input  logic          i_flush
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] WM_CNT   = (AW+1)'(WATERMARK);

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          wr_ok;
  logic          pop;
  logic [127:0]  head;
  logic [31:0]   head_word;

  assign o_rx_full     = (count == FULL_CNT);
  assign o_empty       = (count == '0);
  assign o_almost_full = (count >= WM_CNT);
  assign o_fill_level  = count;

  // Full/empty decisions use the pre-edge count; flush discards both.
  assign wr_ok = i_rx_w_en && !o_rx_full && !i_flush;
  assign pop   = i_rd_en && (i_rd_word == 2'd3) && !o_empty && !i_flush;

  assign head = mem[rptr];

  always_comb begin
    head_word = '0;
    unique case (i_rd_word)
      2'd0: head_word = head[127:96];
      2'd1: head_word = head[95:64];
      2'd2: head_word = head[63:32];
      2'd3: head_word = head[31:0];
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (wr_ok) mem[wptr] <= i_rx_fifo_w_data;
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) o_rd_data <= o_empty ? '0 : head_word;

      if (i_rx_w_en && o_rx_full) o_overflow <= 1'b1;
      else if (i_overflow_clr)    o_overflow <= 1'b0;

      if (i_flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (wr_ok) wptr <= wptr + AW'(1);
        if (pop)   rptr <= rptr + AW'(1);
        if (wr_ok && !pop)      count <= count + (AW+1)'(1);
        else if (pop && !wr_ok) count <= count - (AW+1)'(1);
      end
    end
  end

endmodule
